// File: rtl/change_dispenser_pkg.sv
// Shared coin codes, dispenser state encoding and default timing for the change dispenser.
// Also used by the vending controller that produces the change code.
package change_dispenser_pkg;

  localparam int unsigned EJECT_PULSE_DEF = 4;
  localparam int unsigned TIMEOUT_DEF     = 64;
  localparam int unsigned RETRIES_DEF     = 2;
  localparam int unsigned PEND_W_DEF      = 4;

  typedef enum logic [1:0] {
    C_NONE = 2'b00,
    C_5    = 2'b01,
    C_10   = 2'b10,
    C_15   = 2'b11
  } coin_code_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EJECT = 2'd1,
    ST_WAIT  = 2'd2,
    ST_FAULT = 2'd3
  } disp_state_t;

  // Number of 5rs coins a change code asks for.
  function automatic logic [1:0] coin_units(input logic [1:0] code);
    logic [1:0] units;
    case (code)
      C_NONE:  units = 2'd0;
      C_5:     units = 2'd1;
      C_10:    units = 2'd2;
      C_15:    units = 2'd3;
      default: units = 2'd0;
    endcase
    return units;
  endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Change-code / hopper signal bundle between the vending side (master) and the dispenser (slave).
// AUDIT_EN adds the total_paid coin counter output.
interface change_dispenser_if;
  logic [1:0] change_in;
  logic       coin_sensed;
  logic       hopper_empty;
  logic       eject;
  logic       busy;
  logic       done;
  logic       fault;
  logic       overflow;
`ifdef AUDIT_EN
  logic [15:0] total_paid;

  modport master (
    output change_in, coin_sensed, hopper_empty,
    input  eject, busy, done, fault, overflow, total_paid
  );
  modport slave (
    input  change_in, coin_sensed, hopper_empty,
    output eject, busy, done, fault, overflow, total_paid
  );
`else
  modport master (
    output change_in, coin_sensed, hopper_empty,
    input  eject, busy, done, fault, overflow
  );
  modport slave (
    input  change_in, coin_sensed, hopper_empty,
    output eject, busy, done, fault, overflow
  );
`endif
endinterface

// File: rtl/change_dispenser_timer.sv
// dispense_timer: loadable down-counter shared by the eject pulse and the sensor timeout.
// o_tc flags a count of zero; the counter parks there until reloaded.
module dispense_timer #(
  parameter int unsigned W = 7
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  // Count register: load has priority over decrement.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= {W{1'b0}};
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != {W{1'b0}})) begin
      r_cnt <= r_cnt - {{(W-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_tc = (r_cnt == {W{1'b0}});

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: turns 2-bit change requests into confirmed 5rs coin ejections with retry/fault.
// Optional AUDIT_EN macro adds the saturating total_paid counter.
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int unsigned EJECT_PULSE = EJECT_PULSE_DEF,
  parameter int unsigned TIMEOUT     = TIMEOUT_DEF,
  parameter int unsigned RETRIES     = RETRIES_DEF,
  parameter int unsigned PEND_W      = PEND_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  change_dispenser_if.slave bus
);

  localparam int unsigned TMAX = (TIMEOUT > EJECT_PULSE) ? TIMEOUT : EJECT_PULSE;
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam int unsigned RW   = $clog2(RETRIES + 2);
  localparam int unsigned SW   = PEND_W + 2;
  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

  disp_state_t       r_state;
  logic [PEND_W-1:0] r_pending;
  logic [RW-1:0]     r_retry;
  logic              r_eject, r_busy, r_done, r_fault, r_overflow;

  disp_state_t       w_state_next;
  logic [PEND_W-1:0] w_pend_next;
  logic [RW-1:0]     w_retry_next;
  logic              w_done_next, w_sat, w_confirm;
  logic [SW-1:0]     w_sum;
  logic              w_tmr_load, w_tmr_en, w_tmr_tc;
  logic [TW-1:0]     w_tmr_val;

  // Pending-coin arithmetic: add the request, take off a confirmed coin, saturate.
  always_comb begin
    w_confirm   = (r_state == ST_WAIT) && bus.coin_sensed;
    w_sum       = {2'b00, r_pending} + {{PEND_W{1'b0}}, coin_units(bus.change_in)}
                - {{(SW-1){1'b0}}, w_confirm};
    w_pend_next = r_pending;
    w_sat       = 1'b0;
    if (r_state == ST_FAULT) begin
      w_pend_next = r_pending;
      w_sat       = 1'b0;
    end else if (w_sum > {2'b00, PEND_MAX}) begin
      w_pend_next = PEND_MAX;
      w_sat       = 1'b1;
    end else begin
      w_pend_next = w_sum[PEND_W-1:0];
      w_sat       = 1'b0;
    end
  end

  // Next-state decision; hopper_empty is only consulted when (re)entering EJECT.
  always_comb begin
    w_state_next = r_state;
    w_retry_next = r_retry;
    w_done_next  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_pending != {PEND_W{1'b0}}) begin
          w_state_next = bus.hopper_empty ? ST_FAULT : ST_EJECT;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_EJECT: begin
        w_state_next = w_tmr_tc ? ST_WAIT : ST_EJECT;
      end
      ST_WAIT: begin
        if (w_confirm) begin
          w_retry_next = {RW{1'b0}};
          if (w_pend_next == {PEND_W{1'b0}}) begin
            w_state_next = ST_IDLE;
            w_done_next  = 1'b1;
          end else begin
            w_state_next = bus.hopper_empty ? ST_FAULT : ST_EJECT;
          end
        end else if (w_tmr_tc) begin
          if (r_retry < RW'(RETRIES)) begin
            w_retry_next = r_retry + {{(RW-1){1'b0}}, 1'b1};
            w_state_next = bus.hopper_empty ? ST_FAULT : ST_EJECT;
          end else begin
            w_state_next = ST_FAULT;
          end
        end else begin
          w_state_next = ST_WAIT;
        end
      end
      ST_FAULT: w_state_next = ST_FAULT;
      default:  w_state_next = ST_FAULT;
    endcase
  end

  // Timer restarts on every state change with the length of the state being entered.
  always_comb begin
    w_tmr_load = (w_state_next != r_state);
    w_tmr_en   = !w_tmr_load;
    if (w_state_next == ST_EJECT) begin
      w_tmr_val = TW'(EJECT_PULSE - 1);
    end else begin
      w_tmr_val = TW'(TIMEOUT - 1);
    end
  end

  dispense_timer #(.W(TW)) u_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_en       (w_tmr_en),
    .o_tc       (w_tmr_tc)
  );

  // Dispenser FSM state, pending count and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_pending  <= {PEND_W{1'b0}};
      r_retry    <= {RW{1'b0}};
      r_eject    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_fault    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_pending  <= w_pend_next;
      r_retry    <= w_retry_next;
      r_eject    <= (w_state_next == ST_EJECT);
      r_busy     <= (w_pend_next != {PEND_W{1'b0}}) && (w_state_next != ST_FAULT);
      r_done     <= w_done_next;
      r_fault    <= r_fault | (w_state_next == ST_FAULT);
      r_overflow <= r_overflow | w_sat;
    end
  end

  assign bus.eject    = r_eject;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.fault    = r_fault;
  assign bus.overflow = r_overflow;

`ifdef AUDIT_EN
  logic [15:0] r_total_paid;

  // Lifetime count of confirmed coins, saturating.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_total_paid <= 16'd0;
    end else if (w_confirm && (r_total_paid != 16'hFFFF)) begin
      r_total_paid <= r_total_paid + 16'd1;
    end else begin
      r_total_paid <= r_total_paid;
    end
  end

  assign bus.total_paid = r_total_paid;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: cycle-level behavioural model plus directed scenarios.
module tb_change_dispenser;

  localparam int PULSE = 4;
  localparam int TMO   = 64;
  localparam int TRIES = 3;
  localparam int PMAX  = 15;

  localparam int M_IDLE = 0, M_EJ = 1, M_WAIT = 2, M_FAULT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  change_dispenser_if bus();

  change_dispenser dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  int m_pend, m_mode, m_cnt, m_att, m_paid;
  bit m_done, m_ovf;
  int ej_cnt, done_cnt;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the dispenser's rules written as plain integer bookkeeping per clock.
  task automatic model_step();
    int add, conf, np, nm;
    if (rst) begin
      m_pend = 0; m_mode = M_IDLE; m_cnt = 0; m_att = 1;
      m_done = 0; m_ovf = 0; m_paid = 0;
    end else begin
      add  = int'(bus.change_in);
      conf = (m_mode == M_WAIT && bus.coin_sensed) ? 1 : 0;
      np   = m_pend;
      nm   = m_mode;
      m_done = 0;
      if (m_mode != M_FAULT) begin
        np = m_pend + add - conf;
        if (np > PMAX) begin
          np = PMAX;
          m_ovf = 1;
        end
      end
      case (m_mode)
        M_IDLE: if (m_pend > 0) begin
          if (bus.hopper_empty) nm = M_FAULT;
          else begin nm = M_EJ; m_cnt = 0; end
        end
        M_EJ: begin
          m_cnt++;
          if (m_cnt == PULSE) begin nm = M_WAIT; m_cnt = 0; end
        end
        M_WAIT: begin
          if (conf == 1) begin
            m_att = 1;
            if (np == 0) begin nm = M_IDLE; m_done = 1; end
            else if (bus.hopper_empty) nm = M_FAULT;
            else begin nm = M_EJ; m_cnt = 0; end
          end else begin
            m_cnt++;
            if (m_cnt == TMO) begin
              if (m_att < TRIES) begin
                m_att++;
                if (bus.hopper_empty) nm = M_FAULT;
                else begin nm = M_EJ; m_cnt = 0; end
              end else begin
                nm = M_FAULT;
              end
            end
          end
        end
        default: nm = m_mode;
      endcase
      m_pend = np;
      m_mode = nm;
      if (conf == 1 && m_paid < 65535) m_paid++;
    end
  endtask

  // Single compare process: step the model on the edge, check the DUT just after it.
  always @(posedge clk) begin
    model_step();
    #1;
    chk("eject",    int'(bus.eject),    (m_mode == M_EJ) ? 1 : 0);
    chk("busy",     int'(bus.busy),     (m_pend != 0 && m_mode != M_FAULT) ? 1 : 0);
    chk("done",     int'(bus.done),     int'(m_done));
    chk("fault",    int'(bus.fault),    (m_mode == M_FAULT) ? 1 : 0);
    chk("overflow", int'(bus.overflow), int'(m_ovf));
`ifdef AUDIT_EN
    chk("total_paid", int'(bus.total_paid), m_paid);
`endif
    if (m_mode == M_EJ) ej_cnt++;
    if (m_done) done_cnt++;
  end

  task automatic do_reset();
    rst = 1'b1;
    bus.change_in = 2'b00;
    bus.coin_sensed = 1'b0;
    bus.hopper_empty = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ej_cnt = 0;
    done_cnt = 0;
  endtask

  task automatic request(input logic [1:0] code);
    @(negedge clk);
    bus.change_in = code;
    @(negedge clk);
    bus.change_in = 2'b00;
  endtask

  task automatic wait_eject_end();
    int n;
    n = 0;
    while (!bus.eject && n < 300) begin @(negedge clk); n++; end
    if (!bus.eject) chk("wait_eject_rise", 0, 1);
    n = 0;
    while (bus.eject && n < 20) begin @(negedge clk); n++; end
    if (bus.eject) chk("wait_eject_fall", 1, 0);
  endtask

  task automatic confirm(input int d);
    wait_eject_end();
    repeat (d) @(negedge clk);
    bus.coin_sensed = 1'b1;
    @(negedge clk);
    bus.coin_sensed = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.change_in = 2'b00;
    bus.coin_sensed = 1'b0;
    bus.hopper_empty = 1'b0;
    do_reset();
    chk("rst_eject", int'(bus.eject), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_fault", int'(bus.fault), 0);

    // 1: single 5rs coin, confirmed 3 cycles into WAIT
    request(2'b01);
    confirm(2);
    repeat (3) @(negedge clk);
    chk("t1_eject_cycles", ej_cnt, 4);
    chk("t1_done_count", done_cnt, 1);
    chk("t1_busy_after", int'(bus.busy), 0);
`ifdef AUDIT_EN
    chk("t1_paid", int'(bus.total_paid), 1);
`endif

    // 2: 15rs, stray sensor pulse during EJECT is ignored
    do_reset();
    request(2'b11);
    @(negedge clk);
    bus.coin_sensed = 1'b1;
    @(negedge clk);
    bus.coin_sensed = 1'b0;
    chk("t2_busy_mid", int'(bus.busy), 1);
    confirm(1);
    chk("t2_done_early", done_cnt, 0);
    confirm(3);
    confirm(0);
    repeat (3) @(negedge clk);
    chk("t2_eject_cycles", ej_cnt, 12);
    chk("t2_done_count", done_cnt, 1);

    // 3: no sensor at all -> three attempts then fault
    do_reset();
    request(2'b01);
    n = 0;
    while (!bus.fault && n < 400) begin @(negedge clk); n++; end
    chk("t3_fault_latency", n, 205);
    repeat (5) @(negedge clk);
    chk("t3_eject_cycles", ej_cnt, 3 * PULSE);
    chk("t3_fault", int'(bus.fault), 1);
    chk("t3_eject_off", int'(bus.eject), 0);

    // 4: hopper empty -> fault one cycle after pending is set, no eject
    do_reset();
    bus.hopper_empty = 1'b1;
    request(2'b10);
    chk("t4_fault_before", int'(bus.fault), 0);
    chk("t4_busy_pending", int'(bus.busy), 1);
    @(negedge clk);
    chk("t4_fault_after", int'(bus.fault), 1);
    repeat (6) @(negedge clk);
    chk("t4_eject_cycles", ej_cnt, 0);
    bus.hopper_empty = 1'b0;

    // 5: new request on the confirm cycle of the last coin -> no done, re-eject
    do_reset();
    request(2'b01);
    wait_eject_end();
    @(negedge clk);
    bus.coin_sensed = 1'b1;
    bus.change_in = 2'b01;
    @(negedge clk);
    bus.coin_sensed = 1'b0;
    bus.change_in = 2'b00;
    repeat (2) @(negedge clk);
    chk("t5_no_done", done_cnt, 0);
    chk("t5_busy", int'(bus.busy), 1);
    confirm(4);
    repeat (3) @(negedge clk);
    chk("t5_done_count", done_cnt, 1);
    chk("t5_eject_cycles", ej_cnt, 8);

    // 6: saturate pending, then reset mid-eject
    do_reset();
    repeat (6) begin
      @(negedge clk);
      bus.change_in = 2'b11;
    end
    @(negedge clk);
    bus.change_in = 2'b00;
    chk("t6_overflow", int'(bus.overflow), 1);
    n = 0;
    while (!bus.eject && n < 300) begin @(negedge clk); n++; end
    chk("t6_in_eject", int'(bus.eject), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_eject", int'(bus.eject), 0);
    chk("t6_rst_busy", int'(bus.busy), 0);
    chk("t6_rst_overflow", int'(bus.overflow), 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6_queue_dropped", int'(bus.busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
